// File: rtl/ram_arbiter2.sv
// Round-robin sequencer that serialises two requesters onto one 32x8 RAM.
// Latency: write acks 2 cycles after the grant; a read acks with its data 3 cycles after the grant.
module ram_arbiter2 #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              ram_cs,
    output logic              ram_wrt,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_ACK} state_t;

    state_t r_state;
    logic   r_owner;
    logic   r_we;
    logic   r_last_gnt;
    logic   w_gnt;

    // Under contention the port that did not win last time gets the grant.
    assign w_gnt = (req0 && req1) ? ~r_last_gnt : req1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_owner    <= 1'b0;
            r_we       <= 1'b0;
            r_last_gnt <= 1'b1;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        r_owner    <= w_gnt;
                        r_last_gnt <= w_gnt;
                        r_we       <= w_gnt ? we1 : we0;
                        ram_addr   <= w_gnt ? addr1 : addr0;
                        ram_wdata  <= w_gnt ? wdata1 : wdata0;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: r_state <= r_we ? S_ACK : S_CAPTURE;
                S_CAPTURE: begin
                    if (r_owner) rdata1 <= ram_rdata;
                    else         rdata0 <= ram_rdata;
                    r_state <= S_ACK;
                end
                S_ACK:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes are decoded from state, so an ISSUE cycle that coincides with rst still reaches the RAM.
    assign ram_cs  = (r_state == S_ISSUE);
    assign ram_wrt = ram_cs & r_we;
    assign ram_rd  = ram_cs & ~r_we;
    assign ack0    = (r_state == S_ACK) & ~r_owner;
    assign ack1    = (r_state == S_ACK) & r_owner;
    assign busy    = (r_state != S_IDLE);

endmodule
